// File: rtl/t_vpi_put_pkg.sv
// Shared definitions for the t_vpi_put_resp register-access responder.
// Holds the register address map, register widths, the FSM state type and
// the legality check used to decide when a request must be answered with
// an error.
package t_vpi_put_pkg;

    localparam logic [3:0] ADDR_ONEBIT  = 4'd0;
    localparam logic [3:0] ADDR_TWOONE  = 4'd1;
    localparam logic [3:0] ADDR_ONETWO1 = 4'd2;
    localparam logic [3:0] ADDR_ONETWO2 = 4'd3;
    localparam logic [3:0] ADDR_FTTO3   = 4'd4;
    localparam logic [3:0] ADDR_FTTO4   = 4'd5;
    localparam logic [3:0] ADDR_TESTOUT = 4'd6;
    localparam logic [3:0] ADDR_TESTIN  = 4'd7;
    localparam logic [3:0] ADDR_STATUS  = 4'd8;

    localparam int W_ONEBIT  = 1;
    localparam int W_TWOONE  = 2;
    localparam int W_ONETWO  = 2;
    localparam int W_FTTO    = 4;
    localparam int W_TESTOUT = 24;
    localparam int W_TESTIN  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // True when the access is allowed: address in the map, and writes only
    // to the read/write registers (testin and status are read-only).
    function automatic logic addr_ok(input logic [3:0] addr, input logic write);
        logic ok;
        ok = (addr <= ADDR_STATUS);
        if (write && (addr >= ADDR_TESTIN))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/t_vpi_put_regs.sv
// Test register storage for t_vpi_put_resp.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   we              - write enable (only asserted for writable addresses)
//   addr            - register address
//   wdata           - write data, already trimmed to the widest register
//   testin          - sampled read-only input
//   rdata           - combinational read data, zero-extended; reflects the
//                     value being written this cycle (read-after-write echo)
//   onebit .. testout - register outputs
module t_vpi_put_regs
    import t_vpi_put_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [3:0]           addr,
    input  logic [W_TESTOUT-1:0] wdata,
    input  logic [W_TESTIN-1:0]  testin,
    output logic [DW-1:0]        rdata,
    output logic                 onebit,
    output logic [W_TWOONE-1:0]  twoone,
    output logic [W_ONETWO-1:0]  onetwo,
    output logic [W_FTTO-1:0]    fourthreetwoone,
    output logic [W_TESTOUT-1:0] testout
);

    logic                 onebit_nxt;
    logic [W_TWOONE-1:0]  twoone_nxt;
    logic [W_ONETWO-1:0]  onetwo_nxt;
    logic [W_FTTO-1:0]    ftto_nxt;
    logic [W_TESTOUT-1:0] testout_nxt;
    logic [W_TESTOUT-1:0] rd24;

    // Next values double as the read source so a write echoes its new value.
    always_comb begin
        onebit_nxt  = onebit;
        twoone_nxt  = twoone;
        onetwo_nxt  = onetwo;
        ftto_nxt    = fourthreetwoone;
        testout_nxt = testout;
        if (we) begin
            case (addr)
                ADDR_ONEBIT:  onebit_nxt     = wdata[0];
                ADDR_TWOONE:  twoone_nxt     = wdata[1:0];
                ADDR_ONETWO1: onetwo_nxt[0]  = wdata[0];
                ADDR_ONETWO2: onetwo_nxt[1]  = wdata[0];
                ADDR_FTTO3:   ftto_nxt[1:0]  = wdata[1:0];
                ADDR_FTTO4:   ftto_nxt[3:2]  = wdata[1:0];
                ADDR_TESTOUT: testout_nxt    = wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd24 = '0;
        case (addr)
            ADDR_ONEBIT:  rd24[0]          = onebit_nxt;
            ADDR_TWOONE:  rd24[1:0]        = twoone_nxt;
            ADDR_ONETWO1: rd24[0]          = onetwo_nxt[0];
            ADDR_ONETWO2: rd24[0]          = onetwo_nxt[1];
            ADDR_FTTO3:   rd24[1:0]        = ftto_nxt[1:0];
            ADDR_FTTO4:   rd24[1:0]        = ftto_nxt[3:2];
            ADDR_TESTOUT: rd24             = testout_nxt;
            ADDR_TESTIN:  rd24[15:0]       = testin;
            default:      rd24             = '0;
        endcase
        rdata = DW'(rd24);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            onebit          <= 1'b0;
            twoone          <= '0;
            onetwo          <= '0;
            fourthreetwoone <= '0;
            testout         <= '0;
        end else begin
            onebit          <= onebit_nxt;
            twoone          <= twoone_nxt;
            onetwo          <= onetwo_nxt;
            fourthreetwoone <= ftto_nxt;
            testout         <= testout_nxt;
        end
    end

endmodule

// File: rtl/t_vpi_put_resp.sv
// Register-access responder for the VPI test signals. Accepts one
// read/write request at a time over a valid/ready channel, performs it on
// the test registers, and returns a response with read data and an error
// flag. Keeps saturating transaction and error counters readable at the
// status address.
// Ports:
//   clk, rst_n                         - clock, asynchronous active-low reset
//   req_valid/req_ready/req_write/req_addr/req_wdata - request channel
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err            - response channel
//   testin                             - sampled read-only input
//   onebit, twoone, onetwo, fourthreetwoone, testout - test registers
module t_vpi_put_resp
    import t_vpi_put_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [3:0]           req_addr,
    input  logic [DW-1:0]        req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    input  logic [W_TESTIN-1:0]  testin,
    output logic                 onebit,
    output logic [W_TWOONE-1:0]  twoone,
    output logic [W_ONETWO-1:0]  onetwo,
    output logic [W_FTTO-1:0]    fourthreetwoone,
    output logic [W_TESTOUT-1:0] testout
);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    state_t               state, state_nxt;
    logic                 wr_p0;
    logic [3:0]           addr_p0;
    logic [W_TESTOUT-1:0] wdata_p0;
    logic                 wdata_unused;
    logic [CNTW-1:0]      txn_cnt, err_cnt;
    logic                 acc, err, we;
    logic [DW-1:0]        reg_rdata, rd_mux;

    // Bits above the widest register are never stored.
    assign wdata_unused = ^(req_wdata >> W_TESTOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Stage p0: request capture on acceptance
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            wr_p0    <= req_write;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata[W_TESTOUT-1:0];
        end
    end

    // Stage p1: access, response latch and counters
    assign acc = (state == ACCESS);
    assign err = !addr_ok(addr_p0, wr_p0);
    assign we  = acc && wr_p0 && !err;

    t_vpi_put_regs #(.DW(DW)) u_regs (
        .clk             (clk),
        .rst_n           (rst_n),
        .we              (we),
        .addr            (addr_p0),
        .wdata           (wdata_p0),
        .testin          (testin),
        .rdata           (reg_rdata),
        .onebit          (onebit),
        .twoone          (twoone),
        .onetwo          (onetwo),
        .fourthreetwoone (fourthreetwoone),
        .testout         (testout)
    );

    // Status reports the counters as they stood before this transaction.
    always_comb begin
        if (addr_p0 == ADDR_STATUS) rd_mux = DW'({txn_cnt, err_cnt});
        else                        rd_mux = reg_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            txn_cnt   <= '0;
            err_cnt   <= '0;
        end else if (acc) begin
            rsp_rdata <= rd_mux;
            rsp_err   <= err;
            txn_cnt   <= sat_inc(txn_cnt);
            if (err) err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_t_vpi_put_resp.sv
module tb_t_vpi_put_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] testin;
    logic        onebit;
    logic [1:0]  twoone, onetwo;
    logic [3:0]  fourthreetwoone;
    logic [23:0] testout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    t_vpi_put_resp #(.DW(32), .CNTW(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .testin          (testin),
        .onebit          (onebit),
        .twoone          (twoone),
        .onetwo          (onetwo),
        .fourthreetwoone (fourthreetwoone),
        .testout         (testout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the channel idle.
    task automatic txn(input logic wr, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        rd = rsp_rdata;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b0; testin = '0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_regs", {onebit, twoone, onetwo, fourthreetwoone, testout}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: testout write, upper wdata bits ignored, echo and latency
        txn(1, 4'd6, 32'hFFABCDEF, rd, er, lat);
        check("t1_rdata", rd, 32'h00ABCDEF);
        check("t1_err", er, 0);
        check("t1_latency", lat, 2);
        check("t1_testout", testout, 24'hABCDEF);

        // 2: twoone, fourthreetwoone elements, onetwo[1]
        txn(1, 4'd1, 32'h3, rd, er, lat);
        check("t2_wr1_echo", rd, 32'h3);
        txn(0, 4'd1, 32'h0, rd, er, lat);
        check("t2_rd1", rd, 32'h3);
        check("t2_twoone", twoone, 2'b11);
        txn(1, 4'd4, 32'h2, rd, er, lat);
        check("t2_wr4_echo", rd, 32'h2);
        txn(1, 4'd5, 32'h1, rd, er, lat);
        check("t2_wr5_echo", rd, 32'h1);
        check("t2_ftto", fourthreetwoone, 4'b0110);
        txn(1, 4'd2, 32'hFFFFFFFF, rd, er, lat);
        check("t2_wr2_echo", rd, 32'h1);
        check("t2_onetwo", onetwo, 2'b01);

        // 3: testin read, write to read-only
        testin = 16'h1234;
        txn(0, 4'd7, 32'h0, rd, er, lat);
        check("t3_rd7", rd, 32'h1234);
        check("t3_rd7_err", er, 0);
        txn(1, 4'd7, 32'h5555, rd, er, lat);
        check("t3_wr7_err", er, 1);
        check("t3_regs_kept", {onebit, twoone, onetwo, fourthreetwoone, testout},
              {1'b0, 2'b11, 2'b01, 4'b0110, 24'hABCDEF});

        // 4: illegal address, then status = {txn 9, err 2}
        txn(0, 4'd12, 32'h0, rd, er, lat);
        check("t4_rd12_err", er, 1);
        check("t4_rd12_data", rd, 0);
        txn(0, 4'd8, 32'h0, rd, er, lat);
        check("t4_status", rd, 32'h0009_0002);
        check("t4_status_err", er, 0);

        // 5: response back-pressure with a competing request held
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd0; req_wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        req_write = 1'b0; req_addr = 4'd6; req_wdata = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", rsp_valid, 1);
            check("t5_hold_rdata", rsp_rdata, 32'h1);
            check("t5_hold_ready", req_ready, 0);
            @(negedge clk);
        end
        check("t5_onebit", onebit, 1);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t5_idle_ready", req_ready, 1);
        check("t5_idle_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_accepted", req_ready, 0);
        @(negedge clk);
        check("t5_second_valid", rsp_valid, 1);
        check("t5_second_rdata", rsp_rdata, 32'h00ABCDEF);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        txn(0, 4'd8, 32'h0, rd, er, lat);
        check("t5_status", rd, 32'h000C_0002);

        // 6: asynchronous reset in the middle of an access
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd0; req_wdata = 32'h1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("t6_onebit", onebit, 0);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_req_ready", req_ready, 1);
        check("t6_rdata", rsp_rdata, 0);
        check("t6_testout", testout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_ready_after", req_ready, 1);
        txn(0, 4'd8, 32'h0, rd, er, lat);
        check("t6_status", rd, 0);
        check("t6_onebit_after", onebit, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/t_vpi_put_resp.md
Name: t_vpi_put_resp

Overview:
- Hardware-side register-access responder for the VPI test suite: it is the responding end that services put/get requests aimed at the public test signals.
- A bench initiator issues valid/ready requests (read or write, small address space).
- The block updates or returns the test registers (onebit, twoone, onetwo[], fourthreetwoone[], testout), samples testin, and keeps transaction/error counters.
- It sits beside the DUT top `t` so C and HDL access paths can be cross-checked.

Parameters:
- DW, 32, request/response data width; must be >= 24.
- CNTW, 16, width of transaction and error counters; 2*CNTW <= DW.

Ports:
- clk  input  1  single clock, all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1=write, 0=read.
- req_addr  input  4  register address.
- req_wdata  input  DW  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts response.
- rsp_rdata  output  DW  read data, zero-extended.
- rsp_err  output  1  address illegal or write to read-only.
- testin  input  16  sampled input, read-only.
- onebit  output  1  RW register.
- twoone  output  2  RW register, bits [2:1].
- onetwo  output  2  RW; bit0=onetwo[1], bit1=onetwo[2].
- fourthreetwoone  output  4  RW; [1:0]=elem 3, [3:2]=elem 4.
- testout  output  24  RW register.

Behaviour:
- Address map:
  - 0 onebit
  - 1 twoone
  - 2 onetwo[1]
  - 3 onetwo[2]
  - 4 fourthreetwoone[3]
  - 5 fourthreetwoone[4]
  - 6 testout
  - 7 testin (RO)
  - 8 status (RO) = {txn_cnt, err_cnt} in low 2*CNTW bits
  - 9-15 illegal.
- Write data width: only the register-width LSBs of req_wdata are used; upper bits are ignored. Reads are zero-extended to DW.
- Reset (async, rst_n low): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; all register outputs 0; counters 0. Any in-flight transaction is dropped. Deassertion takes effect on the next posedge.
- FSM states:
  - IDLE: req_ready=1. On posedge with req_valid, capture write/addr/wdata and go to ACCESS.
  - ACCESS: req_ready=0.
    - Write to a RW address: update the register on this edge.
    - Read: latch rdata. testin is sampled at this edge, not the accept edge.
    - Compute err.
    - Increment txn_cnt; increment err_cnt if err.
    - Go to RESP.
  - RESP: rsp_valid=1; rdata/err held stable. On posedge with rsp_ready, go to IDLE and drop rsp_valid.
- Latency: acceptance at edge N, rsp_valid high after edge N+1. Minimum 3 cycles per transaction; one outstanding transaction only.
- Error cases (rsp_err=1, no state change):
  - Write to 7 or 8.
  - Any access to 9-15; rdata=0.
- Write response: rdata = new register value (read-after-write echo); err=0.
- Counters saturate at all-ones and do not wrap. The status read returns counter values before the current transaction's increment.
- req_valid in ACCESS/RESP is ignored (req_ready=0). The initiator must hold the request stable until it is accepted.
- rsp_ready while not in RESP: no effect.
- Register outputs change only in ACCESS; they are stable otherwise.

Decomposition:
- Package t_vpi_put_pkg holds:
  - address localparams (ADDR_ONEBIT…ADDR_STATUS);
  - per-register widths;
  - state enum typedef {IDLE, ACCESS, RESP};
  - a function for the address-legal/writable check.
- One sub-module is natural: t_vpi_put_regs (register storage plus read mux, combinational read, write-enable input). The FSM and counters stay in the top.

Test Plan:
1. Reset then write addr 6 data 32'hFFABCDEF -> testout=24'hABCDEF after the ACCESS edge; rsp_rdata=32'h00ABCDEF; err=0; rsp_valid on cycle 2 after acceptance.
2. Write addr 1 data 3 then read addr 1 -> twoone=2'b11, read rdata=32'h3. Write addr 4 data 2 and addr 5 data 1 -> fourthreetwoone=4'b0110.
3. testin=16'h1234, read addr 7 -> rdata=32'h1234. Then write addr 7 -> err=1 and nothing changes.
4. Read addr 12 -> err=1, rdata=0. Then read addr 8 -> status low half = err_cnt 2 (prior errors), high half = txn_cnt so far.
5. Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable and req_ready=0; a new req_valid is not accepted until one cycle after the rsp_ready handshake.
6. Assert rst_n low during ACCESS of a write to addr 0 -> onebit=0, rsp_valid=0 immediately (async). After release, req_ready=1 and counters are 0.
